// File: rtl/store_buffer_if.sv
// Core/memory-side bundle for the posted-write store buffer.
// The buffer uses the slave view; the core/memory model drives the master view.
interface store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [ADDR_W-1:0] ld_addr;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [CNT_W-1:0]  count;
   logic              empty;

   modport master (
      output cpu_we, cpu_addr, cpu_wdata, ld_addr, mem_ready,
      input  cpu_stall, fwd_hit, fwd_data, mem_valid, mem_addr, mem_wdata, count, empty
   );

   modport slave (
      input  cpu_we, cpu_addr, cpu_wdata, ld_addr, mem_ready,
      output cpu_stall, fwd_hit, fwd_data, mem_valid, mem_addr, mem_wdata, count, empty
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to memory plus youngest-match load forwarding.
// Optional STORE_COALESCE_EN merges a store into a matching non-head entry in place.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         rst,
   store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WA_W-1:0]   r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_merge;
   logic              w_mergeHit;
   logic [PTR_W-1:0]  w_mergeIdx;
   logic              w_fwdHit;
   logic [DATA_W-1:0] w_fwdData;
   logic [3:0]        w_unusedBits;

   function automatic logic [PTR_W-1:0] ageIdx(input logic [PTR_W-1:0] base, input int off);
      return base + PTR_W'(off);
   endfunction

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && bus.mem_ready;
   assign w_merge = bus.cpu_we && w_mergeHit;
   assign w_push  = bus.cpu_we && !w_full && !w_mergeHit;

`ifdef STORE_COALESCE_EN
   // The head is excluded so the entry on the memory handshake never changes under it.
   always_comb begin
      w_mergeHit = 1'b0;
      w_mergeIdx = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (r_valid[ageIdx(r_rdPtr, i)] &&
             r_addr[ageIdx(r_rdPtr, i)] == bus.cpu_addr[ADDR_W-1:2]) begin
            w_mergeHit = 1'b1;
            w_mergeIdx = ageIdx(r_rdPtr, i);
         end
      end
   end
`else
   assign w_mergeHit = 1'b0;
   assign w_mergeIdx = '0;
`endif

   // Oldest-to-youngest scan; a later match overrides, leaving the youngest store's data.
   always_comb begin
      w_fwdHit  = 1'b0;
      w_fwdData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[ageIdx(r_rdPtr, i)] &&
             r_addr[ageIdx(r_rdPtr, i)] == bus.ld_addr[ADDR_W-1:2]) begin
            w_fwdHit  = 1'b1;
            w_fwdData = r_data[ageIdx(r_rdPtr, i)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_pop) begin
            r_valid[r_rdPtr] <= 1'b0;
            r_rdPtr          <= r_rdPtr + PTR_W'(1);
         end
         if (w_push) begin
            r_valid[r_wrPtr] <= 1'b1;
            r_wrPtr          <= r_wrPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: the valid bits decide what is observable.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wrPtr] <= bus.cpu_addr[ADDR_W-1:2];
         r_data[r_wrPtr] <= bus.cpu_wdata;
      end
      if (w_merge) begin
         r_data[w_mergeIdx] <= bus.cpu_wdata;
      end
   end

   assign bus.cpu_stall = bus.cpu_we && w_full && !w_mergeHit;
   assign bus.fwd_hit   = w_fwdHit;
   assign bus.fwd_data  = w_fwdData;
   assign bus.mem_valid = !w_empty;
   assign bus.mem_addr  = {r_addr[r_rdPtr], 2'b00};
   assign bus.mem_wdata = r_data[r_rdPtr];
   assign bus.count     = r_count;
   assign bus.empty     = w_empty;

   assign w_unusedBits  = {bus.cpu_addr[1:0], bus.ld_addr[1:0]};
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
`ifdef STORE_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } store_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   store_t model[$];
   store_t memLog[$];
   int     errors = 0;
   int     checks = 0;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit wordMatch(input logic [31:0] a, input logic [31:0] b);
      return a[31:2] == b[31:2];
   endfunction

   // Youngest non-head entry a coalescing store would overwrite, or -1.
   function automatic int mergeTarget(input logic [31:0] a);
      int t = -1;
      if (COALESCE) begin
         for (int i = 1; i < model.size(); i++) begin
            if (wordMatch(model[i].addr, a)) t = i;
         end
      end
      return t;
   endfunction

   // Reference model: a plain FIFO of stores, updated once per rising edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model.delete();
      end else begin
         bit     popNow;
         int     tgt;
         store_t e;
         popNow = (model.size() > 0) && bus.mem_ready;
         tgt    = mergeTarget(bus.cpu_addr);
         if (bus.cpu_we) begin
            if (tgt >= 0) begin
               model[tgt].data = bus.cpu_wdata;
            end else if (model.size() < DEPTH) begin
               e.addr = bus.cpu_addr;
               e.data = bus.cpu_wdata;
               model.push_back(e);
            end
         end
         if (popNow) void'(model.pop_front());
      end
   end

   always @(posedge clk) begin
      if (rst && bus.mem_valid && bus.mem_ready) begin
         store_t e;
         e.addr = bus.mem_addr;
         e.data = bus.mem_wdata;
         memLog.push_back(e);
      end
   end

   task automatic checkOutput();
      int          n;
      bit          expHit;
      logic [31:0] expFwd;
      bit          expStall;
      n      = model.size();
      expHit = 1'b0;
      expFwd = '0;
      for (int i = 0; i < n; i++) begin
         if (wordMatch(model[i].addr, bus.ld_addr)) begin
            expHit = 1'b1;
            expFwd = model[i].data;
         end
      end
      expStall = bus.cpu_we && (n == DEPTH) && (mergeTarget(bus.cpu_addr) < 0);
      checkVal("count", 32'(bus.count), 32'(n));
      checkVal("empty", 32'(bus.empty), 32'(n == 0));
      checkVal("memValid", 32'(bus.mem_valid), 32'(n > 0));
      checkVal("cpuStall", 32'(bus.cpu_stall), 32'(expStall));
      checkVal("fwdHit", 32'(bus.fwd_hit), 32'(expHit));
      if (n > 0) begin
         checkVal("memAddr", bus.mem_addr, {model[0].addr[31:2], 2'b00});
         checkVal("memWdata", bus.mem_wdata, model[0].data);
      end
      if (expHit) checkVal("fwdData", bus.fwd_data, expFwd);
   endtask

   always @(negedge clk) begin
      #2;
      checkOutput();
   end

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] ld, input logic ready);
      @(negedge clk);
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = data;
      bus.ld_addr   = ld;
      bus.mem_ready = ready;
   endtask

   task automatic drainAll();
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
         #3;
         if (bus.empty) break;
      end
      checkVal("drainDone", 32'(bus.empty), 32'h1);
   endtask

   initial begin
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.ld_addr   = '0;
      bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      checkVal("rstCount", 32'(bus.count), 32'h0);
      checkVal("rstEmpty", 32'(bus.empty), 32'h1);
      checkVal("rstValid", 32'(bus.mem_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Two posted stores held against a stalled memory
      applyStimulus(1'b1, 32'h100, 32'hAAAA0001, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h104, 32'hAAAA0002, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      #3;
      checkVal("t1Count", 32'(bus.count), 32'h2);
      checkVal("t1Valid", 32'(bus.mem_valid), 32'h1);
      checkVal("t1Addr", bus.mem_addr, 32'h100);
      checkVal("t1Data", bus.mem_wdata, 32'hAAAA0001);
      checkVal("t1ModelSize", 32'(model.size()), 32'h2);
      repeat (3) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
         #3;
         checkVal("t1HoldAddr", bus.mem_addr, 32'h100);
         checkVal("t1HoldData", bus.mem_wdata, 32'hAAAA0001);
      end
      drainAll();

      // Full buffer: stall persists through a same-cycle pop, retry then lands
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h500 + 32'(4 * i), 32'(i), 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h510, 32'h5, 32'h0, 1'b0);
      #3;
      checkVal("t2Stall", 32'(bus.cpu_stall), 32'h1);
      checkVal("t2CountFull", 32'(bus.count), 32'h4);
      applyStimulus(1'b1, 32'h510, 32'h5, 32'h0, 1'b1);
      #3;
      checkVal("t2StallOnPop", 32'(bus.cpu_stall), 32'h1);
      applyStimulus(1'b1, 32'h510, 32'h5, 32'h0, 1'b0);
      #3;
      checkVal("t2CountAfterPop", 32'(bus.count), 32'h3);
      checkVal("t2RetryStall", 32'(bus.cpu_stall), 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      #3;
      checkVal("t2CountRefill", 32'(bus.count), 32'h4);
      checkVal("t2HeadAddr", bus.mem_addr, 32'h504);
      drainAll();

      // Forwarding returns the youngest match; bits [1:0] of the load address ignored
      applyStimulus(1'b1, 32'h200, 32'h11, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h200, 32'h22, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h203, 1'b0);
      #3;
      checkVal("t3FwdHit", 32'(bus.fwd_hit), 32'h1);
      checkVal("t3FwdData", bus.fwd_data, 32'h22);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h204, 1'b0);
      #3;
      checkVal("t3FwdMiss", 32'(bus.fwd_hit), 32'h0);
      drainAll();

      // Streaming: push every cycle with memory always ready
      memLog.delete();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'h600 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 32'h0, 1'b1);
         #3;
         checkVal("t4NoStall", 32'(bus.cpu_stall), 32'h0);
         if (i > 0) checkVal("t4Count", 32'(bus.count), 32'h1);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      #3;
      checkVal("t4Empty", 32'(bus.empty), 32'h1);
      checkVal("t4LogSize", 32'(memLog.size()), 32'd10);
      for (int i = 0; i < 10 && i < memLog.size(); i++) begin
         checkVal("t4LogAddr", memLog[i].addr, 32'h600 + 32'(4 * i));
         checkVal("t4LogData", memLog[i].data, 32'hC0DE0000 + 32'(i));
      end

      // Asynchronous reset in the middle of a drain discards everything
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h800 + 32'(4 * i), 32'h80 + 32'(i), 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #3;
      checkVal("t5Count", 32'(bus.count), 32'h0);
      checkVal("t5Empty", 32'(bus.empty), 32'h1);
      checkVal("t5Valid", 32'(bus.mem_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      memLog.delete();
      repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      #3;
      checkVal("t5NoStale", 32'(memLog.size()), 32'h0);
      applyStimulus(1'b1, 32'h900, 32'h99, 32'h0, 1'b1);
      drainAll();
      checkVal("t5NewSize", 32'(memLog.size()), 32'h1);
      if (memLog.size() > 0) checkVal("t5NewAddr", memLog[0].addr, 32'h900);

      // Store to a word already queued behind the head while full
      memLog.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'h30 + 32'(i), 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h304, 32'h55, 32'h0, 1'b0);
      #3;
      checkVal("t6Stall", 32'(bus.cpu_stall), COALESCE ? 32'h0 : 32'h1);
      checkVal("t6Count", 32'(bus.count), 32'h4);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      #3;
      checkVal("t6CountAfter", 32'(bus.count), 32'h4);
      drainAll();
      checkVal("t6LogSize", 32'(memLog.size()), 32'h4);
      for (int i = 0; i < 4 && i < memLog.size(); i++)
         checkVal("t6LogAddr", memLog[i].addr, 32'h300 + 32'(4 * i));
      if (memLog.size() > 1) checkVal("t6MergedData", memLog[1].data, COALESCE ? 32'h55 : 32'h31);

      // Randomized traffic over a small address pool to exercise hits and wraps
      for (int c = 0; c < 600; c++) begin
         if (c == 300) begin
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
         applyStimulus($urandom_range(0, 99) < 60,
                       32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                       $urandom,
                       32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                       $urandom_range(0, 99) < 45);
      end
      drainAll();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the single-cycle MIPS core's data-memory store port.
- Accepts `sw` stores in one cycle and drains them in order to a slower data memory over a valid/ready handshake.
- Forwards buffered data to same-cycle loads so the core never reads stale memory.
- The core stalls only when the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, store data width (word stores only).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_we  input  1  core issues a store this cycle.
- cpu_addr  input  ADDR_W  store byte address; bits [1:0] ignored.
- cpu_wdata  input  DATA_W  store data.
- cpu_stall  output  1  store not accepted; core holds its PC and this store.
- ld_addr  input  ADDR_W  current load address from the core; bits [1:0] ignored.
- fwd_hit  output  1  a buffered store matches ld_addr.
- fwd_data  output  DATA_W  data of the youngest matching entry.
- mem_valid  output  1  head entry presented to memory.
- mem_addr  output  ADDR_W  head entry address, with bits [1:0] forced to 0.
- mem_wdata  output  DATA_W  head entry data.
- mem_ready  input  1  memory accepts the head this cycle.
- count  output  log2(DEPTH)+1  occupancy.
- empty  output  1  count == 0; core uses it as a fence/drain indicator.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr, rd_ptr and count clear to 0. Entry valid bits clear. Outputs take these values:
  - mem_valid = 0, empty = 1, count = 0
  - fwd_hit = 0, cpu_stall = 0 unless cpu_we and full
  - mem_addr and mem_wdata are don't-care.
- Reset during a pending transfer discards all entries. Memory must tolerate mem_valid dropping.
- Storage is a circular FIFO. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (count == DEPTH).
- Push:
  - cpu_we && !full: write the entry at wr_ptr on the next edge, wr_ptr+1, count+1.
  - Push latency is 1 cycle. The entry becomes visible to forwarding and to mem_* on the following cycle.
- Stall: cpu_stall = cpu_we && full, combinational.
  - A pop in the same cycle does not clear the stall.
  - The core retries next cycle.
- Drain:
  - mem_valid = !empty. mem_addr and mem_wdata come from the rd_ptr entry.
  - On mem_valid && mem_ready: rd_ptr+1, count-1.
  - mem_addr and mem_wdata hold stable while mem_valid && !mem_ready.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
  - Push into an empty buffer with mem_ready=1 in the same cycle: no pop that cycle, because mem_valid was 0.
- Forwarding (combinational):
  - Compare ld_addr[ADDR_W-1:2] with every valid entry.
  - fwd_hit = any match. fwd_data = the youngest match in age order from rd_ptr.
  - A store being pushed in the same cycle is not forwarded; the single-cycle core never loads and stores in one instruction.
- Ordering: memory sees stores in program order with no duplication and no loss.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined:
  - A push whose word address matches a valid non-head entry overwrites that entry's data in place.
  - No pointer or count change. Accepted even when full, so cpu_stall = cpu_we && full && !merge_hit.
  - If several entries match, the youngest is updated.
  - The head entry is never modified, so handshake stability holds.
- Undefined: every push allocates a new entry; duplicates drain separately.

Test Plan:
- Reset with mem_ready=0, then push 0x100/0xAAAA0001 and 0x104/0xAAAA0002 → count=2, mem_valid=1, mem_addr=0x100. Hold mem_ready=0 for 3 cycles → mem_* unchanged.
- Fill to DEPTH=4 with mem_ready=0, then push a 5th store → cpu_stall=1, count=4. Next cycle mem_ready=1 → head pops, count=3. Retry succeeds → count=4.
- Push 0x200/0x11, then 0x200/0x22, then ld_addr=0x203 → fwd_hit=1, fwd_data=0x22. ld_addr=0x204 → fwd_hit=0.
- mem_ready=1 continuously with a push every cycle for 10 cycles → count stays at 1. Memory receives all 10 stores in order and cpu_stall is never asserted.
- Assert rst=0 mid-drain with count=3 → immediately mem_valid=0, empty=1, count=0. After release, old data is never emitted.
- With STORE_COALESCE_EN defined: buffer holds 0x300 (head), 0x304, 0x308, 0x30C (full). Push 0x304/0x55 → cpu_stall=0, count=4, drained order 0x300, 0x304=0x55, 0x308, 0x30C. Without the macro, the same push stalls.
